// File: rtl/pc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pc_ctrl_unit -- program counter block for the multicycle MIPS core.
//
// Owns the PC register and selects the next PC from: sequential, branch,
// j, jr, jal, eret, or the exception vector. It also latches the jal return
// address and the exception PC, and counts retired instructions.
//
// Handshake: pc_wr is a single-cycle commit strobe from the controller.
//   Every rising edge with pc_wr=1 retires one instruction: the PC, EPC and
//   link registers and the counter update at that edge. With pc_wr=0 nothing
//   changes. An exception is taken only on a pc_wr edge while exc_req is
//   high. exc_ack is then high for exactly the following cycle. The source
//   must drop exc_req on exc_ack, or the exception is taken again on the
//   next pc_wr.
//
// Optional feature (macro PC_ALIGN_TRAP_EN): a jr or eret target with
//   bits [1:0] != 0 raises an alignment exception. The extra output
//   align_err pulses together with exc_ack.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   pc_wr       commit the next PC at this edge
//   npc_sel     0 seq, 1 branch, 2 j, 3 jr, 4 jal, 5 eret, 6-7 seq
//   br_cond     0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez,
//               6-7 never taken
//   zero, neg   ALU flags used for the branch condition
//   imm26       instruction immediate; [15:0] is the branch offset
//   reg_in      rs value used as the jr target
//   exc_req     level exception request
//   pc          current instruction address
//   pc_add4     pc + 4 (combinational)
//   link_addr   return address from the last jal
//   epc         exception PC
//   exc_ack     one-cycle pulse after an exception is taken
//   br_taken    branch condition true while npc_sel selects branch
//   instret     retired-instruction counter (wraps)
//   align_err   (PC_ALIGN_TRAP_EN only) misaligned jr/eret trap pulse
// ---------------------------------------------------------------------------
module pc_ctrl_unit #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC   = 32'h0000_3000,
  parameter logic [ADDR_W-1:0]    EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_wr,
  input  logic [2:0]        npc_sel,
  input  logic [2:0]        br_cond,
  input  logic              zero,
  input  logic              neg,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic              exc_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_add4,
  output logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] epc,
  output logic              exc_ack,
  output logic              br_taken,
  output logic [CNT_W-1:0]  instret
`ifdef PC_ALIGN_TRAP_EN
  ,
  output logic              align_err
`endif
);

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_J    = 3'd2;
  localparam logic [2:0] SEL_JR   = 3'd3;
  localparam logic [2:0] SEL_JAL  = 3'd4;
  localparam logic [2:0] SEL_ERET = 3'd5;

  // The jump target replaces the low 28 bits of pc+4.
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

  logic              cond_true;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] npc;
  logic              take_exc;
  logic [ADDR_W-1:0] exc_epc;
  logic              take_align;

  assign pc_add4 = pc + ADDR_W'(4);

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'd0:    cond_true = zero;
      3'd1:    cond_true = !zero;
      3'd2:    cond_true = neg | zero;
      3'd3:    cond_true = !neg & !zero;
      3'd4:    cond_true = neg;
      3'd5:    cond_true = !neg;
      default: cond_true = 1'b0;
    endcase
  end

  assign br_taken = (npc_sel == SEL_BR) && cond_true;

  // Sign-extended word offset taken from imm26[15:0].
  assign br_offset = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign j_target  = (pc_add4 & ~LOW28_MASK) | ADDR_W'({imm26, 2'b00});

  always_comb begin
    npc = pc_add4;
    case (npc_sel)
      SEL_BR:          npc = br_taken ? (pc_add4 + br_offset) : pc_add4;
      SEL_J, SEL_JAL:  npc = j_target;
      SEL_JR:          npc = reg_in;
      SEL_ERET:        npc = epc;
      default:         npc = pc_add4;
    endcase
  end

  // Exception arbitration. An external request beats an alignment fault,
  // and in that case epc records the current pc.
  always_comb begin
    take_align = 1'b0;
`ifdef PC_ALIGN_TRAP_EN
    take_align = !exc_req &&
                 (((npc_sel == SEL_JR)   && (reg_in[1:0] != 2'b00)) ||
                  ((npc_sel == SEL_ERET) && (epc[1:0]    != 2'b00)));
`endif
    take_exc = exc_req || take_align;
    exc_epc  = take_align ? npc : pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      link_addr <= '0;
      epc       <= '0;
      exc_ack   <= 1'b0;
      instret   <= '0;
    end else if (pc_wr) begin
      instret <= instret + CNT_W'(1);
      exc_ack <= take_exc;
      if (take_exc) begin
        pc  <= EXC_VECTOR;
        epc <= exc_epc;
      end else begin
        pc <= npc;
        if (npc_sel == SEL_JAL) link_addr <= pc_add4;
      end
    end else begin
      exc_ack <= 1'b0;
    end
  end

`ifdef PC_ALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        align_err <= 1'b0;
    else if (pc_wr) align_err <= take_align;
    else            align_err <= 1'b0;
  end
`else
  // Only read when the alignment trap is compiled in.
  logic unused_align;
  assign unused_align = take_align;
`endif

endmodule

// File: tb/tb_pc_ctrl_unit.sv
module tb_pc_ctrl_unit;

  logic        clk;
  logic        rst;
  logic        pc_wr;
  logic [2:0]  npc_sel;
  logic [2:0]  br_cond;
  logic        zero;
  logic        neg;
  logic [25:0] imm26;
  logic [31:0] reg_in;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc_add4;
  logic [31:0] link_addr;
  logic [31:0] epc;
  logic        exc_ack;
  logic        br_taken;
  logic [31:0] instret;
`ifdef PC_ALIGN_TRAP_EN
  logic        align_err;
`endif

  pc_ctrl_unit dut (
    .clk       (clk),
    .rst       (rst),
    .pc_wr     (pc_wr),
    .npc_sel   (npc_sel),
    .br_cond   (br_cond),
    .zero      (zero),
    .neg       (neg),
    .imm26     (imm26),
    .reg_in    (reg_in),
    .exc_req   (exc_req),
    .pc        (pc),
    .pc_add4   (pc_add4),
    .link_addr (link_addr),
    .epc       (epc),
    .exc_ack   (exc_ack),
    .br_taken  (br_taken),
    .instret   (instret)
`ifdef PC_ALIGN_TRAP_EN
    ,
    .align_err (align_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] link;
    logic [31:0] epc;
    logic [31:0] ir;
    logic        ack;
    logic        al;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] last_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: registered state is valid from the negedge after each commit edge.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc",        pc,                mon_e.pc);
      chk("link_addr", link_addr,         mon_e.link);
      chk("epc",       epc,               mon_e.epc);
      chk("exc_ack",   {31'b0, exc_ack},  {31'b0, mon_e.ack});
      chk("instret",   instret,           mon_e.ir);
`ifdef PC_ALIGN_TRAP_EN
      chk("align_err", {31'b0, align_err}, {31'b0, mon_e.al});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic wr, input logic [2:0] sel, input logic [2:0] cond,
                      input logic z, input logic n, input logic [25:0] imm,
                      input logic [31:0] rin, input logic exc, input logic exp_br,
                      input logic [31:0] e_pc, input logic [31:0] e_link,
                      input logic [31:0] e_epc, input logic e_ack,
                      input logic [31:0] e_ir, input logic e_al);
    exp_t e;
    @(negedge clk);
    pc_wr = wr; npc_sel = sel; br_cond = cond; zero = z; neg = n;
    imm26 = imm; reg_in = rin; exc_req = exc;
    #1;
    chk("pc_add4",  pc_add4, last_pc + 32'd4);
    chk("br_taken", {31'b0, br_taken}, {31'b0, exp_br});
    @(posedge clk);
    e.pc = e_pc; e.link = e_link; e.epc = e_epc; e.ack = e_ack; e.ir = e_ir; e.al = e_al;
    exp_q.push_back(e);
    last_pc = e_pc;
  endtask

  // pc_wr low with every other input toggling: nothing may change.
  task automatic idle(input int cycles, input logic [31:0] e_pc, input logic [31:0] e_link,
                      input logic [31:0] e_epc, input logic [31:0] e_ir);
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      pc_wr = 1'b0;
      npc_sel = 3'($urandom_range(0, 7));
      br_cond = 3'($urandom_range(0, 7));
      zero = 1'($urandom_range(0, 1));
      neg = 1'($urandom_range(0, 1));
      imm26 = 26'($urandom);
      reg_in = $urandom;
      exc_req = 1'($urandom_range(0, 1));
      #1;
      chk("idle_pc_add4", pc_add4, last_pc + 32'd4);
      @(posedge clk);
      e.pc = e_pc; e.link = e_link; e.epc = e_epc; e.ack = 1'b0; e.ir = e_ir; e.al = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // Reset asserted in the middle of a cycle with a commit pending.
  task automatic mid_reset();
    @(negedge clk);
    pc_wr = 1'b1; npc_sel = 3'd2; imm26 = 26'h0000C40; exc_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_pc",      pc,      32'h0000_3000);
    chk("rst_instret", instret, 32'd0);
    chk("rst_ack",     {31'b0, exc_ack}, 32'd0);
    @(negedge clk);
    pc_wr = 1'b0;
    rst = 1'b0;
    last_pc = 32'h0000_3000;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; pc_wr = 1'b0; npc_sel = 3'd0; br_cond = 3'd0; zero = 1'b0; neg = 1'b0;
    imm26 = 26'd0; reg_in = 32'd0; exc_req = 1'b0;
    last_pc = 32'h0000_3000;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //   wr sel cond z n imm            rin           exc br  pc            link          epc           ack ir  al
    step(0, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_3000, 32'h0,        32'h0,        0,  0,  0);
    step(1, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_3004, 32'h0,        32'h0,        0,  1,  0);
    step(1, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_3008, 32'h0,        32'h0,        0,  2,  0);
    step(1, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_300C, 32'h0,        32'h0,        0,  3,  0);
    mid_reset();
    // branches
    step(1, 2, 0, 0, 0, 26'h0000C04,   32'h0,        0,  0, 32'h0000_3010, 32'h0,        32'h0,        0,  1,  0);
    step(1, 1, 0, 1, 0, 26'h000FFFE,   32'h0,        0,  1, 32'h0000_300C, 32'h0,        32'h0,        0,  2,  0);
    step(1, 2, 0, 0, 0, 26'h0000C04,   32'h0,        0,  0, 32'h0000_3010, 32'h0,        32'h0,        0,  3,  0);
    step(1, 1, 0, 0, 0, 26'h000FFFE,   32'h0,        0,  0, 32'h0000_3014, 32'h0,        32'h0,        0,  4,  0);
    step(1, 2, 0, 0, 0, 26'h0000C04,   32'h0,        0,  0, 32'h0000_3010, 32'h0,        32'h0,        0,  5,  0);
    step(1, 1, 4, 0, 1, 26'h0000004,   32'h0,        0,  1, 32'h0000_3024, 32'h0,        32'h0,        0,  6,  0);
    step(1, 1, 3, 0, 0, 26'h0000001,   32'h0,        0,  1, 32'h0000_302C, 32'h0,        32'h0,        0,  7,  0);
    step(1, 1, 2, 0, 0, 26'h0000001,   32'h0,        0,  0, 32'h0000_3030, 32'h0,        32'h0,        0,  8,  0);
    step(1, 1, 1, 0, 0, 26'h000FFFF,   32'h0,        0,  1, 32'h0000_3030, 32'h0,        32'h0,        0,  9,  0);
    step(1, 1, 5, 0, 1, 26'h0000005,   32'h0,        0,  0, 32'h0000_3034, 32'h0,        32'h0,        0,  10, 0);
    step(1, 1, 7, 1, 1, 26'h0000005,   32'h0,        0,  0, 32'h0000_3038, 32'h0,        32'h0,        0,  11, 0);
    step(1, 1, 2, 1, 0, 26'h0000002,   32'h0,        0,  1, 32'h0000_3044, 32'h0,        32'h0,        0,  12, 0);
    // jal / jr
    step(1, 2, 0, 0, 0, 26'h0000C08,   32'h0,        0,  0, 32'h0000_3020, 32'h0,        32'h0,        0,  13, 0);
    step(1, 4, 0, 0, 0, 26'h0000C10,   32'h0,        0,  0, 32'h0000_3040, 32'h0000_3024, 32'h0,       0,  14, 0);
    step(1, 3, 0, 0, 0, 26'h0,         32'h0000_3024, 0, 0, 32'h0000_3024, 32'h0000_3024, 32'h0,       0,  15, 0);
    // exception beats jal, then eret
    step(1, 2, 0, 0, 0, 26'h0000C14,   32'h0,        0,  0, 32'h0000_3050, 32'h0000_3024, 32'h0,       0,  16, 0);
    step(1, 4, 0, 0, 0, 26'h0000C10,   32'h0,        1,  0, 32'h0000_4180, 32'h0000_3024, 32'h0000_3050, 1, 17, 0);
    step(0, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_4180, 32'h0000_3024, 32'h0000_3050, 0, 17, 0);
    step(1, 5, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_3050, 32'h0000_3024, 32'h0000_3050, 0, 18, 0);
    idle(10, 32'h0000_3050, 32'h0000_3024, 32'h0000_3050, 32'd18);
    // exception beats eret
    step(1, 5, 0, 0, 0, 26'h0,         32'h0,        1,  0, 32'h0000_4180, 32'h0000_3024, 32'h0000_3050, 1, 19, 0);
    step(1, 5, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_3050, 32'h0000_3024, 32'h0000_3050, 0, 20, 0);
    // misaligned jr
`ifdef PC_ALIGN_TRAP_EN
    step(1, 3, 0, 0, 0, 26'h0,         32'h0000_3006, 0, 0, 32'h0000_4180, 32'h0000_3024, 32'h0000_3006, 1, 21, 1);
    step(1, 3, 0, 0, 0, 26'h0,         32'h0000_3006, 1, 0, 32'h0000_4180, 32'h0000_3024, 32'h0000_4180, 1, 22, 0);
    step(0, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_4180, 32'h0000_3024, 32'h0000_4180, 0, 22, 0);
`else
    step(1, 3, 0, 0, 0, 26'h0,         32'h0000_3006, 0, 0, 32'h0000_3006, 32'h0000_3024, 32'h0000_3050, 0, 21, 0);
    step(1, 3, 0, 0, 0, 26'h0,         32'h0000_3006, 1, 0, 32'h0000_4180, 32'h0000_3024, 32'h0000_3006, 1, 22, 0);
    step(0, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_4180, 32'h0000_3024, 32'h0000_3006, 0, 22, 0);
`endif
    // address wrap-around and jump region taken from pc+4
`ifdef PC_ALIGN_TRAP_EN
    step(1, 3, 0, 0, 0, 26'h0,         32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0000_3024, 32'h0000_4180, 0, 23, 0);
    step(1, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_0000, 32'h0000_3024, 32'h0000_4180, 0, 24, 0);
    step(1, 2, 0, 0, 0, 26'h3FFFFFF,   32'h0,        0,  0, 32'h0FFF_FFFC, 32'h0000_3024, 32'h0000_4180, 0, 25, 0);
`else
    step(1, 3, 0, 0, 0, 26'h0,         32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0000_3024, 32'h0000_3006, 0, 23, 0);
    step(1, 0, 0, 0, 0, 26'h0,         32'h0,        0,  0, 32'h0000_0000, 32'h0000_3024, 32'h0000_3006, 0, 24, 0);
    step(1, 2, 0, 0, 0, 26'h3FFFFFF,   32'h0,        0,  0, 32'h0FFF_FFFC, 32'h0000_3024, 32'h0000_3006, 0, 25, 0);
`endif

    @(negedge clk);
    pc_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl_unit.md
Name: pc_ctrl_unit

Overview:
- Next-generation PC block for the multicycle MIPS core. It owns the PC register and computes the next PC from one of seven sources.
- Supports six branch conditions plus jumps, jr, jal, eret and exception redirect.
- Captures EPC and the return address, and counts retired instructions.
- Sits between the multicycle controller (pc_wr, npc_sel, br_cond), the ALU flags (zero, neg) and the register file (reg_in, link writeback).

Parameters:
- ADDR_W, 32, PC/address width (>=28)
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VECTOR, 32'h0000_4180, exception handler entry
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- pc_wr  in  1  controller strobe: commit next PC this edge
- npc_sel  in  3  0 seq, 1 branch, 2 j, 3 jr, 4 jal, 5 eret, 6-7 seq
- br_cond  in  3  0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez, 6-7 never-taken
- zero  in  1  ALU result == 0
- neg  in  1  ALU result sign (rs compared against 0)
- imm26  in  26  instruction immediate field
- reg_in  in  ADDR_W  rs value for jr
- exc_req  in  1  level exception request, held until exc_ack
- pc  out  ADDR_W  current instruction address
- pc_add4  out  ADDR_W  pc+4, combinational
- link_addr  out  ADDR_W  return address latched by last jal
- epc  out  ADDR_W  exception PC
- exc_ack  out  1  one-cycle pulse when an exception is taken
- br_taken  out  1  combinational: branch condition true (npc_sel==1)
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset values: pc=RESET_PC, link_addr=0, epc=0, exc_ack=0, instret=0. Reset may occur at any time, including mid-instruction; the next cycle restarts cleanly.
- State changes only on the clk rising edge with pc_wr=1. Without pc_wr, all registers hold and exc_ack=0.
- Next-PC candidates (all ADDR_W arithmetic; carries beyond ADDR_W are discarded, so wrap-around is mod 2^ADDR_W):
  - seq = pc+4
  - branch = pc+4 + (sext(imm26[15:0])<<2) if br_taken, else pc+4
  - j/jal = {pc_add4[ADDR_W-1:28], imm26, 2'b00}
  - jr = reg_in
  - eret = epc
- br_taken conditions:
  - beq: zero
  - bne: !zero
  - blez: neg|zero
  - bgtz: !neg&!zero
  - bltz: neg
  - bgez: !neg
- jal: link_addr <= pc+4 in the same edge as the PC update.
- Exception: if exc_req=1 at an edge with pc_wr=1:
  - pc <= EXC_VECTOR, epc <= pc, exc_ack=1 for the following cycle.
  - npc_sel is ignored and link_addr is not written.
  - Exception takes priority over every npc_sel, including eret and jal.
  - If exc_req is still high after exc_ack, it is taken again at the next pc_wr. The source must drop it on ack.
- eret does not modify epc.
- instret increments by 1 on every pc_wr edge, including exception edges, and wraps at 2^CNT_W.
- Latency: pc updates one edge after pc_wr is sampled. pc_add4 and br_taken are combinational, zero latency.

Optional Feature:
- Macro: PC_ALIGN_TRAP_EN.
- Defined:
  - A jr or eret target with bits [1:0] != 0 at a pc_wr edge is treated as an exception: pc <= EXC_VECTOR, epc <= faulting target address, exc_ack pulses.
  - Extra output port align_err (1 bit) pulses together with that exc_ack.
  - If exc_req is also high on the same edge, epc <= pc (exc_req wins) and align_err stays 0.
- Undefined:
  - Targets are used as-is and no align_err port exists.

Test Plan:
- Reset, then 3 seq pc_wr pulses -> pc 0x3000 -> 0x3004 -> 0x3008 -> 0x300C, instret=3. Assert rst mid-run -> pc=0x3000, instret=0 immediately.
- pc=0x3010, beq, zero=1, imm16=0xFFFE -> pc=0x300C. Same with zero=0 -> pc=0x3014. bltz with neg=1, imm16=0x0004 -> pc=0x3024.
- pc=0x3020, jal, imm26=0x0000C10 -> pc=0x3040, link_addr=0x3024. Then jr with reg_in=0x3024 -> pc=0x3024.
- pc=0x3050, exc_req=1 with npc_sel=jal on the same pc_wr edge -> pc=0x4180, epc=0x3050, link_addr unchanged, exc_ack high exactly one cycle. Then eret -> pc=0x3050.
- pc_wr=0 for 10 cycles with all inputs toggling -> pc, epc, link_addr, instret unchanged, exc_ack=0.
- With PC_ALIGN_TRAP_EN: jr reg_in=0x3006 -> pc=0x4180, epc=0x3006, align_err pulse. Without the macro -> pc=0x3006.
